// File: rtl/uart_rx_mv.sv
// uart_rx_mv: UART receiver with 3-sample majority vote per bit, runtime
// parity / stop-bit selection latched at the start edge, and error/break
// reporting. Bit timing advances only on baud ticks (i_valid), with
// OVERSAMPLE ticks per bit.
module uart_rx_mv #(
    parameter int N_DATA     = 8,
    parameter int OVERSAMPLE = 16,
    parameter int NB_TICK    = 4
) (
    input  logic              i_clock,
    input  logic              i_reset,
    input  logic              i_valid,
    input  logic              i_data,
    input  logic [1:0]        i_parity_mode,
    input  logic              i_stop_bits,
    output logic [N_DATA-1:0] o_data,
    output logic              o_valid,
    output logic              o_parity_err,
    output logic              o_frame_err,
    output logic              o_break
);

    // Tick-counter landmarks inside one bit period. The counter value of the
    // start-detect tick is 0, so the bit centre is at OVERSAMPLE/2 and the
    // vote is decided one tick later.
    localparam logic [NB_TICK-1:0] TICK_ONE  = NB_TICK'(1);
    localparam logic [NB_TICK-1:0] TICK_LAST = NB_TICK'(OVERSAMPLE - 1);
    localparam logic [NB_TICK-1:0] TICK_S0   = NB_TICK'(OVERSAMPLE / 2 - 1);
    localparam logic [NB_TICK-1:0] TICK_S1   = NB_TICK'(OVERSAMPLE / 2);
    localparam logic [NB_TICK-1:0] TICK_DEC  = NB_TICK'(OVERSAMPLE / 2 + 1);
    localparam logic [3:0]         LAST_BIT  = 4'(N_DATA - 1);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } state_t;

    state_t              r_state;
    state_t              w_state_next;

    logic                r_sync1;
    logic                r_sync2;
    logic                r_armed;
    logic [NB_TICK-1:0]  r_tick;
    logic                r_s0;
    logic                r_s1;
    logic [3:0]          r_bit;
    logic [N_DATA-1:0]   r_shift;
    logic [1:0]          r_par_mode;
    logic                r_stop2;
    logic                r_par_bit;
    logic                r_par_err;
    logic                r_frame_err;

    logic                w_start;
    logic                w_decide;
    logic                w_bit;
    logic                w_par_en;
    logic                w_last_stop;
    logic                w_done;
    logic                w_ferr;

    // 2-of-3 vote over the samples around the bit centre
    function automatic logic majority3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

    // Next-state logic and per-tick decode (start edge, decision tick, completion)
    always_comb begin
        w_start      = 1'b0;
        w_decide     = 1'b0;
        w_bit        = majority3(r_s0, r_s1, r_sync2);
        w_par_en     = (r_par_mode == 2'b01) || (r_par_mode == 2'b10);
        w_last_stop  = ~r_stop2 | (r_bit == 4'd1);
        w_state_next = r_state;

        if (i_valid) begin
            if (r_state == ST_IDLE) begin
                w_start = r_armed & ~r_sync2;
            end else begin
                w_decide = (r_tick == TICK_DEC);
            end
        end else begin
            w_start  = 1'b0;
            w_decide = 1'b0;
        end

        case (r_state)
            ST_IDLE: begin
                if (w_start) begin
                    w_state_next = ST_START;
                end else begin
                    w_state_next = ST_IDLE;
                end
            end
            ST_START: begin
                if (w_decide) begin
                    // A high start decision is a glitch: drop back silently
                    w_state_next = w_bit ? ST_IDLE : ST_DATA;
                end else begin
                    w_state_next = ST_START;
                end
            end
            ST_DATA: begin
                if (w_decide && (r_bit == LAST_BIT)) begin
                    w_state_next = w_par_en ? ST_PARITY : ST_STOP;
                end else begin
                    w_state_next = ST_DATA;
                end
            end
            ST_PARITY: begin
                if (w_decide) begin
                    w_state_next = ST_STOP;
                end else begin
                    w_state_next = ST_PARITY;
                end
            end
            ST_STOP: begin
                // Leave mid-bit so a back-to-back start edge is not missed
                if (w_decide && w_last_stop) begin
                    w_state_next = ST_IDLE;
                end else begin
                    w_state_next = ST_STOP;
                end
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase

        w_done = w_decide & (r_state == ST_STOP) & w_last_stop;
        w_ferr = r_frame_err | ~w_bit;
    end

    // FSM state register
    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Two-flop synchroniser on the asynchronous RX pin, free-running every clock
    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            r_sync1 <= 1'b1;
            r_sync2 <= 1'b1;
        end else begin
            r_sync1 <= i_data;
            r_sync2 <= r_sync1;
        end
    end

    // Tick-gated datapath: arming, tick counter, vote samples, shift register, error accumulation
    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            r_armed     <= 1'b0;
            r_tick      <= '0;
            r_s0        <= 1'b1;
            r_s1        <= 1'b1;
            r_bit       <= 4'd0;
            r_shift     <= '0;
            r_par_mode  <= 2'b00;
            r_stop2     <= 1'b0;
            r_par_bit   <= 1'b0;
            r_par_err   <= 1'b0;
            r_frame_err <= 1'b0;
        end else if (i_valid) begin
            if (r_state == ST_IDLE) begin
                if (w_start) begin
                    // The start tick itself is count 0, the next tick is count 1
                    r_armed     <= 1'b0;
                    r_tick      <= TICK_ONE;
                    r_bit       <= 4'd0;
                    r_par_mode  <= i_parity_mode;
                    r_stop2     <= i_stop_bits;
                    r_par_bit   <= 1'b0;
                    r_par_err   <= 1'b0;
                    r_frame_err <= 1'b0;
                end else if (r_sync2) begin
                    // Only a high line re-arms, so a held break cannot retrigger
                    r_armed <= 1'b1;
                end
            end else begin
                r_tick <= (r_tick == TICK_LAST) ? '0 : (r_tick + TICK_ONE);
                if (r_tick == TICK_S0) begin
                    r_s0 <= r_sync2;
                end
                if (r_tick == TICK_S1) begin
                    r_s1 <= r_sync2;
                end
                if (w_decide) begin
                    case (r_state)
                        ST_START: begin
                            r_bit <= 4'd0;
                        end
                        ST_DATA: begin
                            // LSB arrives first, so shift in from the top
                            r_shift <= {w_bit, r_shift[N_DATA-1:1]};
                            r_bit   <= (r_bit == LAST_BIT) ? 4'd0 : (r_bit + 4'd1);
                        end
                        ST_PARITY: begin
                            r_par_bit <= w_bit;
                            r_par_err <= (^r_shift) ^ w_bit ^ (r_par_mode == 2'b10);
                        end
                        ST_STOP: begin
                            if (!w_bit) begin
                                r_frame_err <= 1'b1;
                            end
                            r_bit <= r_bit + 4'd1;
                        end
                        default: begin
                            r_bit <= r_bit;
                        end
                    endcase
                end
            end
        end
    end

    // Registered outputs: word and flags load together with a one-cycle valid pulse
    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            o_data       <= '0;
            o_valid      <= 1'b0;
            o_parity_err <= 1'b0;
            o_frame_err  <= 1'b0;
            o_break      <= 1'b0;
        end else begin
            o_valid <= w_done;
            if (w_done) begin
                o_data       <= r_shift;
                o_parity_err <= r_par_err;
                o_frame_err  <= w_ferr;
                o_break      <= w_ferr & ~(|r_shift) & ~r_par_bit;
            end
        end
    end

endmodule

// File: doc/uart_rx_mv.md
Name: uart_rx_mv

Overview:
- Parametrised UART receiver with majority-vote bit sampling, runtime parity and stop-bit selection, and error and break reporting.
- Successor to the fixed 16x-oversample receiver. Sits between the RX pin (after the pad) and the RX FIFO / command interface.
- Timing is driven by an external baud-tick enable i_valid, at OVERSAMPLE ticks per bit.

Parameters:
- N_DATA, 8, data bits per frame (5..9), sent LSB first.
- OVERSAMPLE, 16, i_valid ticks per bit; must be even and at least 4.
- NB_TICK, 4, tick counter width; must satisfy 2^NB_TICK >= OVERSAMPLE.

Ports:
- i_clock  in  1  system clock.
- i_reset  in  1  synchronous, active-high reset.
- i_valid  in  1  baud tick enable; the receiver advances only on cycles where i_valid=1.
- i_data  in  1  serial RX line, asynchronous, idles high.
- i_parity_mode  in  2  parity select: 00 none, 01 even, 10 odd, 11 treated as none.
- i_stop_bits  in  1  stop-bit select: 0 one stop bit, 1 two stop bits.
- o_data  out  N_DATA  last received word.
- o_valid  out  1  one-i_clock pulse marking a completed frame.
- o_parity_err  out  1  parity mismatch flag for the frame in o_data.
- o_frame_err  out  1  flag set when any stop bit was sampled as 0.
- o_break  out  1  break detected: data, parity and stop bits all 0.

Behaviour:
- Reset: i_reset is synchronous, active-high; clock i_clock.
  - Under reset: state=IDLE; all outputs 0; the synchroniser flops load 1; armed=0.
- Synchroniser: two flops on i_data, clocked every i_clock and not gated by i_valid. The synchronised line is rx_s.
- Tick gating: all other state changes only on cycles with i_valid=1. With i_valid=0 everything holds.
- Armed flag:
  - Set on any tick in IDLE with rx_s=1.
  - Cleared on start detection.
  - A line held low (break) cannot retrigger until it has returned high.
- Frame timing:
  - Start is detected on tick T0: state IDLE, armed=1, rx_s=0. The tick counter and bit index reset to 0.
  - Bit k (k=0 is start) has centre C = T0 + k*OVERSAMPLE + OVERSAMPLE/2.
  - The bit value is the majority of rx_s at ticks C-1, C and C+1, and is decided on tick C+1.
- Mode latch: i_parity_mode and i_stop_bits are captured at T0. Changes mid-frame are ignored.
- FSM states:
  - IDLE -> START: on start detection.
  - START -> IDLE on start decision = 1 (false start); no outputs, no flags change.
  - START -> DATA on start decision = 0.
  - DATA: shifts each decided bit into an internal register, LSB first. After N_DATA bits, goes to PARITY if parity is enabled, else to STOP.
  - PARITY: decides one bit.
    - Even mode: error when XOR(data, parity bit) = 1.
    - Odd mode: error when that XOR = 0.
  - STOP: decides 1 or 2 stop bits; any stop bit decided as 0 sets the frame error.
    - Goes to IDLE right after the decision tick of the last stop bit (mid-bit), so back-to-back frames are accepted.
- Completion (i_clock edge after the last stop decision tick):
  - o_data, o_parity_err, o_frame_err and o_break are loaded together; o_valid=1 for exactly one cycle.
  - Flags hold until the next completion. Data is delivered even when errors are flagged.
- o_break = frame_err AND every decided data bit 0 AND (parity bit 0 or parity disabled).
- Latency, for the default parameters, 8N1 with a tick every clock: stop decision at T0+153, o_valid at T0+154.
- Tick counter: counts 0..OVERSAMPLE-1 and wraps to 0 at each bit boundary; it never overflows NB_TICK.
- Simultaneous events: a tick in the same cycle as i_reset is ignored; reset wins.
- Reset mid-frame: the frame is discarded, no o_valid, state=IDLE, armed=0.

Test Plan:
- 8N1, mode 00, i_valid=1 every clock, send 0x55 -> o_valid pulse at T0+154, o_data=0x55, all flags 0.
- Even parity, send 0xA3 (four 1s) with parity bit 1 -> o_data=0xA3, o_parity_err=1. Repeat with parity bit 0 -> o_parity_err=0.
- Odd parity, 2 stop bits, send 0x0F with second stop bit driven 0 -> o_frame_err=1, o_break=0, o_data=0x0F.
- Line low for 3 ticks then high, in IDLE -> no o_valid; a following valid 0x3C frame is received correctly.
- Line held low for 2 frame times then high, then 0x81 sent -> one o_valid with o_data=0x00, o_break=1, o_frame_err=1. No further o_valid until the line goes high; then 0x81 is received with all flags 0.
- i_valid asserted every 3rd clock with 0xC6; single-tick glitch on a data-bit centre tick; i_reset pulsed mid-frame on a second frame -> first frame yields o_data=0xC6 (majority vote rejects the glitch); second frame gives no o_valid, and outputs return to 0.
